// File: rtl/vib_pkg.sv
// Shared width helpers for the vector input buffer.
// Entry layout is {eof, packed vector}; lane i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
package vib_pkg;

    // Pointer width for a storage array of the given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    // Packed entry width for N lanes of DATA_WIDTH bits plus the eof flag.
    function automatic int unsigned entry_w(input int unsigned n, input int unsigned data_width);
        return n * data_width + 1;
    endfunction

endpackage

// File: rtl/vib_storage.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module vib_storage #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are never reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_input_buffer.sv
// Circular FIFO of N-lane vectors with a registered output stage, dequeue handshake,
// occupancy status and sticky overflow / saturating drop statistics.
module vector_input_buffer
    import vib_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IB_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enqueue,
    input  logic                        eof_in,
    input  logic [DATA_WIDTH-1:0]       vector_in [N-1:0],
    input  logic                        dequeue,
    input  logic                        clear_stats,
    output logic                        valid_out,
    output logic                        eof_out,
    output logic [DATA_WIDTH-1:0]       vector_out [N-1:0],
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(IB_DEPTH):0]   count,
    output logic                        overflow,
    output logic [CNT_WIDTH-1:0]        drop_count
);

    localparam int unsigned PTR_W = ptr_w(IB_DEPTH);
    localparam int unsigned CNT_W = cnt_w(IB_DEPTH);
    localparam int unsigned VEC_W = N * DATA_WIDTH;
    localparam int unsigned ENT_W = entry_w(N, DATA_WIDTH);

    typedef struct packed {
        logic             eof;
        logic [VEC_W-1:0] vec;
    } entry_t;

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 eof_q, eof_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic [VEC_W-1:0]     in_vec_c;
    entry_t               wr_entry_c;
    entry_t               rd_entry_c;
    logic [ENT_W-1:0]     rd_data_c;

    logic full_c, empty_c;
    logic accept_c, drop_c, pop_c, load_c;

    // Lane packing between the unpacked ports and the stored form.
    for (genvar i = 0; i < N; i++) begin : g_lanes
        assign in_vec_c[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
        assign vector_out[i] = vec_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign full_c  = (count_q == CNT_W'(IB_DEPTH));
    assign empty_c = (count_q == CNT_W'(0));

    // Full is sampled at the edge, so a same-cycle pop never rescues an enqueue.
    assign accept_c = enqueue && !full_c;
    assign drop_c   = enqueue && full_c;
    assign pop_c    = valid_q && dequeue;
    assign load_c   = !empty_c && (!valid_q || pop_c);

    assign wr_entry_c = '{eof: eof_in, vec: in_vec_c};
    assign rd_entry_c = entry_t'(rd_data_c);

    vib_storage #(
        .WIDTH (ENT_W),
        .DEPTH (IB_DEPTH)
    ) u_storage (
        .clk     (clk),
        .we_i    (accept_c),
        .waddr_i (head_q),
        .wdata_i (wr_entry_c),
        .raddr_i (tail_q),
        .rdata_o (rd_data_c)
    );

    // Next-state for pointers, occupancy, output stage and statistics.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        eof_d   = eof_q;
        vec_d   = vec_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (accept_c) begin
            head_d = head_q + PTR_W'(1);
        end

        if (load_c) begin
            tail_d  = tail_q + PTR_W'(1);
            valid_d = 1'b1;
            eof_d   = rd_entry_c.eof;
            vec_d   = rd_entry_c.vec;
        end else if (pop_c) begin
            valid_d = 1'b0;
        end

        case ({accept_c, load_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (clear_stats) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop_c) begin
            ovf_d = 1'b1;
            if (drop_q != {CNT_WIDTH{1'b1}}) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            vec_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            vec_q   <= vec_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_out  = valid_q;
    assign eof_out    = eof_q;
    assign full       = full_c;
    assign empty      = empty_c;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vector_input_buffer.sv
// Directed, table-driven bench for vector_input_buffer (N=4, 8-bit lanes, depth 4, 3-bit drop counter).
module tb_vector_input_buffer;

    logic       clk;
    logic       rst;
    logic       enqueue;
    logic       eof_in;
    logic [7:0] vector_in [3:0];
    logic       dequeue;
    logic       clear_stats;
    logic       valid_out;
    logic       eof_out;
    logic [7:0] vector_out [3:0];
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic [2:0] drop_count;

    int checks = 0;
    int errors = 0;

    vector_input_buffer #(
        .N          (4),
        .DATA_WIDTH (8),
        .IB_DEPTH   (4),
        .CNT_WIDTH  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enqueue     (enqueue),
        .eof_in      (eof_in),
        .vector_in   (vector_in),
        .dequeue     (dequeue),
        .clear_stats (clear_stats),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .vector_out  (vector_out),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       enq;
        logic       eof;
        logic [7:0] val;
        logic       deq;
        logic       clr;
        logic       ev;
        logic [7:0] ebase;
        logic       eeof;
        logic [2:0] ecnt;
        logic       eovf;
        logic [2:0] edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic enq, input logic eof, input logic [7:0] val,
                                input logic deq, input logic clr, input logic ev,
                                input logic [7:0] ebase, input logic eeof, input logic [2:0] ecnt,
                                input logic eovf, input logic [2:0] edrop);
        vec_t r;
        r.enq = enq; r.eof = eof; r.val = val; r.deq = deq; r.clr = clr;
        r.ev = ev; r.ebase = ebase; r.eeof = eeof; r.ecnt = ecnt; r.eovf = eovf; r.edrop = edrop;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] vo_packed();
        return {vector_out[3], vector_out[2], vector_out[1], vector_out[0]};
    endfunction

    function automatic logic [31:0] exp_vec(input logic [7:0] base);
        logic [7:0] l1, l2, l3;
        l1 = base + 8'd1;
        l2 = base + 8'd2;
        l3 = base + 8'd3;
        return {l3, l2, l1, base};
    endfunction

    task automatic drive(input logic enq, input logic eof, input logic [7:0] val,
                         input logic deq, input logic clr);
        enqueue     = enq;
        eof_in      = eof;
        dequeue     = deq;
        clear_stats = clr;
        for (int i = 0; i < 4; i++) vector_in[i] = val + 8'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] base,
                           input logic eeof, input logic [2:0] ecnt);
        chk({tag, " valid"}, 32'(valid_out), 32'(ev));
        if (ev) begin
            chk({tag, " vector"}, vo_packed(), exp_vec(base));
            chk({tag, " eof"}, 32'(eof_out), 32'(eeof));
        end
        chk({tag, " count"}, 32'(count), 32'(ecnt));
        chk({tag, " full"}, 32'(full), 32'(ecnt == 3'd4));
        chk({tag, " empty"}, 32'(empty), 32'(ecnt == 3'd0));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        chk("reset valid", 32'(valid_out), 32'd0);
        chk("reset eof", 32'(eof_out), 32'd0);
        chk("reset vector", vo_packed(), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset drops", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with dequeue held low, overflow with a clear on the 4th drop, then drain.
        //            enq  eof  val    deq  clr  ev   base   eeof cnt   ovf  drop
        tbl.push_back(mk(1, 0, 8'h01, 0, 0, 0, 8'h00, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 8'h01, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(1, 1, 8'h03, 0, 0, 1, 8'h01, 0, 3'd2, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h04, 0, 0, 1, 8'h01, 0, 3'd3, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h05, 0, 0, 1, 8'h01, 0, 3'd4, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h50, 0, 0, 1, 8'h01, 0, 3'd4, 1, 3'd1));
        tbl.push_back(mk(1, 0, 8'h51, 0, 0, 1, 8'h01, 0, 3'd4, 1, 3'd2));
        tbl.push_back(mk(1, 0, 8'h52, 0, 0, 1, 8'h01, 0, 3'd4, 1, 3'd3));
        tbl.push_back(mk(1, 0, 8'h53, 0, 1, 1, 8'h01, 0, 3'd4, 0, 3'd0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h02, 0, 3'd3, 0, 3'd0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h03, 1, 3'd2, 0, 3'd0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h04, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h05, 0, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 3'd0, 0, 3'd0));
        // Refill, drop while popping (no bypass), then dequeue 1,0,0,1 and drain.
        tbl.push_back(mk(1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h11, 0, 0, 1, 8'h10, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h12, 0, 0, 1, 8'h10, 0, 3'd2, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h13, 0, 0, 1, 8'h10, 0, 3'd3, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h14, 0, 0, 1, 8'h10, 0, 3'd4, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h60, 1, 0, 1, 8'h11, 0, 3'd3, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 3'd3, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 3'd3, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h12, 0, 3'd2, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h13, 0, 3'd1, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h14, 0, 3'd0, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 3'd0, 1, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 3'd0, 0, 3'd0));

        foreach (tbl[r]) begin
            drive(tbl[r].enq, tbl[r].eof, tbl[r].val, tbl[r].deq, tbl[r].clr);
            tick();
            chk_out($sformatf("row%0d", r), tbl[r].ev, tbl[r].ebase, tbl[r].eeof, tbl[r].ecnt);
            chk($sformatf("row%0d overflow", r), 32'(overflow), 32'(tbl[r].eovf));
            chk($sformatf("row%0d drops", r), 32'(drop_count), 32'(tbl[r].edrop));
        end

        // Latency: single accept at edge k, visible after k+1, gone after k+2.
        drive(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
        tick();
        chk_out("lat k", 1'b0, 8'h00, 1'b0, 3'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk_out("lat k+1", 1'b1, 8'hAA, 1'b0, 3'd0);
        tick();
        chk_out("lat k+2", 1'b0, 8'h00, 1'b0, 3'd0);

        // Streaming 20 vectors through with dequeue high; pointers wrap several times.
        for (int j = 0; j < 22; j++) begin
            logic [7:0] v;
            v = 8'h40 + 8'(j);
            drive(j < 20, (j == 7) || (j == 19), v, 1'b1, 1'b0);
            tick();
            if (j == 0) begin
                chk_out("stream 0", 1'b0, 8'h00, 1'b0, 3'd1);
            end else if (j <= 20) begin
                chk_out($sformatf("stream %0d", j), 1'b1, v - 8'd1,
                        (j - 1 == 7) || (j - 1 == 19), (j < 20) ? 3'd1 : 3'd0);
            end else begin
                chk_out("stream end", 1'b0, 8'h00, 1'b0, 3'd0);
            end
        end

        // Drop counter saturates at all-ones.
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 8'h70 + 8'(j), 1'b0, 1'b0);
            tick();
        end
        chk_out("sat fill", 1'b1, 8'h70, 1'b0, 3'd4);
        for (int j = 0; j < 9; j++) begin
            drive(1'b1, 1'b0, 8'hE0, 1'b0, 1'b0);
            tick();
        end
        chk("sat drops", 32'(drop_count), 32'd7);
        chk("sat overflow", 32'(overflow), 32'd1);
        chk_out("sat held", 1'b1, 8'h70, 1'b0, 3'd4);

        // Asynchronous reset mid-stream with count=3 and valid_out=1.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk_out("pre-rst", 1'b1, 8'h71, 1'b0, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(valid_out), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst empty", 32'(empty), 32'd1);
        chk("async rst overflow", 32'(overflow), 32'd0);
        chk("async rst drops", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        tick();
        chk_out("post-rst k", 1'b0, 8'h00, 1'b0, 3'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk_out("post-rst k+1", 1'b1, 8'h33, 1'b0, 3'd0);
        tick();
        chk_out("post-rst k+2", 1'b0, 8'h00, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
